// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer
//   Buffers a command frame, streams it into the transmit side of a uart core,
//   then collects a fixed-length response (with an inter-word timeout) and
//   offers it to the host through a drain stream.
//
// Ports
//   clk, rst          : clock (rising edge) / asynchronous active-low reset
//   load_*            : host writes command words into the tx buffer (IDLE only)
//   tx_len_i/rx_len_i : words to send / expect, sampled when start is accepted
//   start_i           : begin a transaction (IDLE only)
//   busy_o            : transaction in progress (SEND or RECV)
//   done_o            : one-cycle pulse when a transaction ends
//   timeout_o         : sticky timeout flag, cleared by the next accepted start
//   uart_t*_o/_i      : AXI-stream to/from the uart core
//   resp_*            : drain stream for the collected response (IDLE only)
//   state_o           : debug view of the FSM state (0 IDLE, 1 SEND, 2 RECV)
//
// Handshakes: a word moves on a rising edge where valid and ready are both 1.
// A producer holding valid keeps its data stable until that edge; ready may
// change freely.
module uart_cmd_sequencer #(
  parameter int DATA_WIDTH_P     = 8,
  parameter int MAX_TX_BYTES_P   = 16,
  parameter int MAX_RX_BYTES_P   = 8,
  parameter int TIMEOUT_CYCLES_P = 100000
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [DATA_WIDTH_P-1:0]               load_data_i,
  input  logic                                  load_valid_i,
  output logic                                  load_ready_o,
  input  logic [$clog2(MAX_TX_BYTES_P+1)-1:0]   tx_len_i,
  input  logic [$clog2(MAX_RX_BYTES_P+1)-1:0]   rx_len_i,
  input  logic                                  start_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic                                  timeout_o,
  output logic [DATA_WIDTH_P-1:0]               uart_tdata_o,
  output logic                                  uart_tvalid_o,
  input  logic                                  uart_tready_i,
  input  logic [DATA_WIDTH_P-1:0]               uart_tdata_i,
  input  logic                                  uart_tvalid_i,
  output logic                                  uart_tready_o,
  output logic [DATA_WIDTH_P-1:0]               resp_data_o,
  output logic                                  resp_valid_o,
  input  logic                                  resp_ready_i,
  output logic [$clog2(MAX_RX_BYTES_P+1)-1:0]   resp_count_o,
  output logic [1:0]                            state_o
);
  localparam int TXC_W = $clog2(MAX_TX_BYTES_P + 1);
  localparam int RXC_W = $clog2(MAX_RX_BYTES_P + 1);
  localparam int TXI_W = (MAX_TX_BYTES_P > 1) ? $clog2(MAX_TX_BYTES_P) : 1;
  localparam int RXI_W = (MAX_RX_BYTES_P > 1) ? $clog2(MAX_RX_BYTES_P) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES_P > 1) ? $clog2(TIMEOUT_CYCLES_P) : 1;
  localparam logic [TXC_W-1:0] TX_MAX   = TXC_W'(MAX_TX_BYTES_P);
  localparam logic [RXC_W-1:0] RX_MAX   = RXC_W'(MAX_RX_BYTES_P);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES_P - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, RECV = 2'd2} state_t;
  state_t state_q, state_d;

  logic [DATA_WIDTH_P-1:0] tx_buf [MAX_TX_BYTES_P];
  logic [DATA_WIDTH_P-1:0] rx_buf [MAX_RX_BYTES_P];
  logic [TXC_W-1:0]        wr_ptr, rd_ptr, tx_len_q;
  logic [RXC_W-1:0]        rx_head, rx_cnt, rx_len_q;
  logic [TMO_W-1:0]        tmo_cnt;
  logic [DATA_WIDTH_P-1:0] tdata_q;
  logic                    done_q, timeout_q;

  logic                    load_fire, start_fire, drain_fire, tx_hs, tx_last;
  logic                    rx_take, rx_done, rx_tmo;
  logic [TXC_W-1:0]        wr_ptr_eff, tx_len_clamp, rd_ptr_inc;
  logic [RXC_W-1:0]        rx_len_clamp, rx_cnt_nxt;
  logic [DATA_WIDTH_P-1:0] first_word;

  always_comb begin
    load_fire    = load_ready_o && load_valid_i;
    start_fire   = (state_q == IDLE) && start_i;
    drain_fire   = resp_valid_o && resp_ready_i;
    // A load in the same cycle as start already counts toward the frame.
    wr_ptr_eff   = wr_ptr + TXC_W'(load_fire);
    tx_len_clamp = (tx_len_i < wr_ptr_eff) ? tx_len_i : wr_ptr_eff;
    rx_len_clamp = (rx_len_i > RX_MAX) ? RX_MAX : rx_len_i;
    // Word 0 may be arriving on the load port in the very cycle of start.
    first_word   = (load_fire && (wr_ptr == '0)) ? load_data_i : tx_buf[0];
    tx_hs        = (state_q == SEND) && uart_tready_i;
    rd_ptr_inc   = rd_ptr + 1'b1;
    tx_last      = (rd_ptr_inc == tx_len_q);
    rx_take      = (state_q == RECV) && uart_tvalid_i && (rx_cnt < rx_len_q);
    rx_cnt_nxt   = rx_cnt + RXC_W'(rx_take);
    rx_done      = (state_q == RECV) && (rx_cnt_nxt == rx_len_q);
    rx_tmo       = (state_q == RECV) && !rx_done && !uart_tvalid_i && (tmo_cnt == TMO_LAST);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_fire) state_d = (tx_len_clamp == '0) ? RECV : SEND;
      SEND: if (tx_hs && tx_last) state_d = RECV;
      RECV: if (rx_done || rx_tmo) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy_o        = (state_q != IDLE);
    uart_tvalid_o = (state_q == SEND);
    uart_tdata_o  = tdata_q;
    uart_tready_o = 1'b1;
    load_ready_o  = (state_q == IDLE) && (wr_ptr != TX_MAX);
    resp_valid_o  = (state_q == IDLE) && (rx_cnt != '0);
    resp_count_o  = rx_cnt;
    resp_data_o   = (rx_cnt != '0) ? rx_buf[rx_head[RXI_W-1:0]] : '0;
    done_o        = done_q;
    timeout_o     = timeout_q;
    state_o       = state_q;
  end

  // Datapath: buffers, pointers, timeout counter, registered tx data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_TX_BYTES_P; i++) tx_buf[i] <= '0;
      for (int i = 0; i < MAX_RX_BYTES_P; i++) rx_buf[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tx_len_q  <= '0;
      rx_head   <= '0;
      rx_cnt    <= '0;
      rx_len_q  <= '0;
      tmo_cnt   <= '0;
      tdata_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_fire) begin
            tx_buf[wr_ptr[TXI_W-1:0]] <= load_data_i;
            wr_ptr <= wr_ptr + 1'b1;
          end
          if (drain_fire) begin
            rx_head <= rx_head + 1'b1;
            rx_cnt  <= rx_cnt - 1'b1;
          end
          // Start wins over a same-cycle drain: the rx buffer is flushed.
          if (start_fire) begin
            tx_len_q  <= tx_len_clamp;
            rx_len_q  <= rx_len_clamp;
            rx_head   <= '0;
            rx_cnt    <= '0;
            rd_ptr    <= '0;
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
            tdata_q   <= first_word;
          end
        end
        SEND: begin
          if (tx_hs) begin
            rd_ptr <= rd_ptr_inc;
            if (!tx_last) tdata_q <= tx_buf[rd_ptr_inc[TXI_W-1:0]];
          end
        end
        RECV: begin
          // rx_head is 0 throughout RECV, so the fill count is the write index.
          if (rx_take) begin
            rx_buf[rx_cnt[RXI_W-1:0]] <= uart_tdata_i;
            rx_cnt <= rx_cnt_nxt;
          end
          if (uart_tvalid_i) tmo_cnt <= '0;
          else               tmo_cnt <= tmo_cnt + 1'b1;
          if (rx_done || rx_tmo) begin
            done_q <= 1'b1;
            wr_ptr <= '0;
          end
          if (rx_tmo) timeout_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
module tb_uart_cmd_sequencer;
  localparam int DW    = 8;
  localparam int MTX   = 16;
  localparam int MRX   = 8;
  localparam int TMO   = 40;
  localparam int TXC_W = $clog2(MTX + 1);
  localparam int RXC_W = $clog2(MRX + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0]    load_data_i = '0;
  logic             load_valid_i = 1'b0;
  logic             load_ready_o;
  logic [TXC_W-1:0] tx_len_i = '0;
  logic [RXC_W-1:0] rx_len_i = '0;
  logic             start_i = 1'b0;
  logic             busy_o, done_o, timeout_o;
  logic [DW-1:0]    uart_tdata_o;
  logic             uart_tvalid_o;
  logic             uart_tready_i = 1'b0;
  logic [DW-1:0]    uart_tdata_i = '0;
  logic             uart_tvalid_i = 1'b0;
  logic             uart_tready_o;
  logic [DW-1:0]    resp_data_o;
  logic             resp_valid_o;
  logic             resp_ready_i = 1'b0;
  logic [RXC_W-1:0] resp_count_o;
  logic [1:0]       dbg_state;

  uart_cmd_sequencer #(
    .DATA_WIDTH_P(DW), .MAX_TX_BYTES_P(MTX), .MAX_RX_BYTES_P(MRX), .TIMEOUT_CYCLES_P(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .load_data_i(load_data_i), .load_valid_i(load_valid_i), .load_ready_o(load_ready_o),
    .tx_len_i(tx_len_i), .rx_len_i(rx_len_i), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
    .uart_tdata_o(uart_tdata_o), .uart_tvalid_o(uart_tvalid_o), .uart_tready_i(uart_tready_i),
    .uart_tdata_i(uart_tdata_i), .uart_tvalid_i(uart_tvalid_i), .uart_tready_o(uart_tready_o),
    .resp_data_o(resp_data_o), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_count_o(resp_count_o), .state_o(dbg_state)
  );

  // ---------------- model state / scoreboard ----------------
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [DW-1:0] m_tx[$];      // words held in the command buffer
  logic [DW-1:0] exp_q[$];     // words the uart must still receive, in order
  logic [DW-1:0] m_rx[$];      // words held in the response buffer
  logic [DW-1:0] sent_log[$];  // words the uart actually took this transaction
  int          m_rxlen = 0;
  bit          m_timeout = 0;
  bit          m_to_exp = 0;
  bit          phase_busy = 0;
  bit          force_stall = 0;
  bit          prev_stall = 0;
  logic [DW-1:0] prev_data = '0;
  int          n_sent = 0;
  int          n_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    m_tx.delete(); exp_q.delete(); m_rx.delete(); sent_log.delete();
    phase_busy = 0; m_timeout = 0; m_to_exp = 0; n_sent = 0;
  endtask

  // uart transmit-side readiness: random, or forced low for stall tests.
  always @(posedge clk) begin
    #1;
    uart_tready_i = force_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 0;
    end else begin
      chk("tready_const", uart_tready_o, 1);
      if (prev_stall) begin
        chk("tvalid_hold", uart_tvalid_o, 1);
        chk("tdata_hold", uart_tdata_o, prev_data);
      end
      if (uart_tvalid_o && uart_tready_i) begin
        chk("tx_word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("tx_word", uart_tdata_o, exp_q[0]);
          exp_q.delete(0);
        end
        sent_log.push_back(uart_tdata_o);
        n_sent++;
      end
      prev_stall = uart_tvalid_o && !uart_tready_i;
      prev_data  = uart_tdata_o;

      if (phase_busy) begin
        if (done_o) begin
          chk("busy_at_done", busy_o, 0);
          chk("tx_all_sent", exp_q.size(), 0);
          chk("resp_count_at_done", resp_count_o, m_rx.size());
          m_timeout = m_to_exp;
          m_tx.delete();
          n_done++;
          phase_busy = 0;
        end else begin
          chk("busy", busy_o, 1);
          chk("resp_valid_busy", resp_valid_o, 0);
          chk("load_ready_busy", load_ready_o, 0);
        end
      end else begin
        chk("busy_idle", busy_o, 0);
        chk("done_idle", done_o, 0);
        chk("tvalid_idle", uart_tvalid_o, 0);
        chk("load_ready", load_ready_o, m_tx.size() < MTX);
        chk("resp_valid", resp_valid_o, m_rx.size() != 0);
        chk("resp_count", resp_count_o, m_rx.size());
        if (m_rx.size() != 0) chk("resp_data", resp_data_o, m_rx[0]);
      end
      chk("timeout_flag", timeout_o, m_timeout);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [DW-1:0] d);
    load_data_i = d; load_valid_i = 1'b1;
    cyc();
    load_valid_i = 1'b0;
    if (m_tx.size() < MTX) m_tx.push_back(d);
  endtask

  task automatic do_start(input int txl, input int rxl, input bit wl, input logic [DW-1:0] ld);
    int n;
    start_i = 1'b1; tx_len_i = TXC_W'(txl); rx_len_i = RXC_W'(rxl);
    if (wl) begin load_valid_i = 1'b1; load_data_i = ld; end
    cyc();
    start_i = 1'b0; load_valid_i = 1'b0;
    if (wl && m_tx.size() < MTX) m_tx.push_back(ld);
    n = (txl < m_tx.size()) ? txl : m_tx.size();
    exp_q.delete(); sent_log.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(m_tx[i]);
    m_rxlen = (rxl > MRX) ? MRX : rxl;
    m_rx.delete(); m_timeout = 0; n_sent = 0; phase_busy = 1;
  endtask

  task automatic wait_tx_drained();
    int k = 0;
    while (exp_q.size() != 0 && k < 1000) begin cyc(); k++; end
    chk("send_phase_end", exp_q.size(), 0);
  endtask

  task automatic respond(input int nw, input bit fixed, input logic [DW-1:0] fv);
    wait_tx_drained();
    for (int i = 0; i < nw; i++) begin
      repeat ($urandom_range(0, 4)) cyc();
      uart_tdata_i  = fixed ? fv : DW'($urandom_range(0, 255));
      uart_tvalid_i = 1'b1;
      if (m_rx.size() < m_rxlen) m_rx.push_back(uart_tdata_i);
      cyc();
      uart_tvalid_i = 1'b0;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    clear_model();
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic wait_done();
    int k = 0;
    while (phase_busy && k < 500) begin cyc(); k++; end
    if (phase_busy) begin
      chk("done_wait", phase_busy, 0);
      apply_reset();
    end
  endtask

  task automatic drain();
    resp_ready_i = 1'b1;
    cyc();
    resp_ready_i = 1'b0;
    if (m_rx.size() != 0) m_rx.delete(0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0, n, txl, rxl, nl, nw, nd;
    bit wl;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_tvalid", uart_tvalid_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_tdata", uart_tdata_o, 0);
    chk("rst_resp_data", resp_data_o, 0);
    chk("rst_resp_count", resp_count_o, 0);
    cyc();
    rst = 1'b1;
    cyc();
    chk("load_ready_after_reset", load_ready_o, 1);

    // Basic command / single-word echo.
    do_load(8'h03); do_load(8'h05); do_load(8'h2a);
    d0 = n_done; m_to_exp = 0;
    do_start(3, 1, 0, 0);
    respond(1, 1, 8'h08);
    wait_done();
    cyc();
    chk("t1_sent_count", n_sent, 3);
    chk("t1_w0", sent_log.size() > 0 ? sent_log[0] : 8'hxx, 8'h03);
    chk("t1_w1", sent_log.size() > 1 ? sent_log[1] : 8'hxx, 8'h05);
    chk("t1_w2", sent_log.size() > 2 ? sent_log[2] : 8'hxx, 8'h2a);
    chk("t1_done_once", n_done - d0, 1);
    chk("t1_resp_count", resp_count_o, 1);
    chk("t1_resp_data", resp_data_o, 8'h08);
    chk("t1_timeout", timeout_o, 0);
    drain();
    chk("t1_drained", resp_count_o, 0);

    // Long back-pressure in the middle of SEND.
    for (int i = 0; i < 5; i++) do_load(DW'($urandom_range(0, 255)));
    do_start(5, 0, 0, 0);
    n = 0;
    while (n_sent < 2 && n < 200) begin cyc(); n++; end
    force_stall = 1;
    repeat (20) cyc();
    chk("t2_tvalid_held", uart_tvalid_o, 1);
    force_stall = 0;
    wait_done();
    chk("t2_sent_count", n_sent, 5);

    // Timeout after a partial response.
    do_load(8'h11);
    m_to_exp = 1;
    do_start(1, 2, 0, 0);
    wait_tx_drained();
    uart_tdata_i = 8'h5a; uart_tvalid_i = 1'b1;
    m_rx.push_back(8'h5a);
    cyc();
    uart_tvalid_i = 1'b0;
    n = 0;
    while (!done_o && n < 200) begin cyc(); n++; end
    chk("t3_timeout_latency", n, TMO);
    wait_done();
    chk("t3_timeout_set", timeout_o, 1);
    chk("t3_partial_count", resp_count_o, 1);
    chk("t3_partial_data", resp_data_o, 8'h5a);

    // Zero-length transaction; also clears the sticky timeout.
    m_to_exp = 0;
    do_start(0, 0, 0, 0);
    chk("t6_timeout_cleared", timeout_o, 0);
    n = 0;
    while (!done_o && n < 10) begin cyc(); n++; end
    chk("t6_done_within_2", n <= 2, 1);
    wait_done();
    chk("t6_no_traffic", n_sent, 0);

    // Overfill the command buffer, then ask for more than it holds.
    for (int i = 0; i < MTX; i++) do_load(DW'(i + 8'h40));
    chk("t4_full_ready", load_ready_o, 0);
    do_load(8'hee);
    do_start(20, 1, 0, 0);
    respond(1, 0, 0);
    wait_done();
    chk("t4_sent_count", n_sent, MTX);
    chk("t4_last_word", sent_log.size() == MTX ? sent_log[MTX-1] : 8'hxx, 8'h4f);

    // Reset in the middle of SEND.
    for (int i = 0; i < 4; i++) do_load(DW'($urandom_range(0, 255)));
    do_start(4, 1, 0, 0);
    force_stall = 0;
    n = 0;
    while (n_sent < 1 && n < 200) begin cyc(); n++; end
    rst = 1'b0;
    #1;
    chk("t5_busy_in_reset", busy_o, 0);
    chk("t5_tvalid_in_reset", uart_tvalid_o, 0);
    clear_model();
    repeat (2) cyc();
    rst = 1'b1;
    #1;
    chk("t5_resp_count", resp_count_o, 0);
    chk("t5_load_ready", load_ready_o, 1);
    cyc();

    // Randomised transactions.
    for (int t = 0; t < 30; t++) begin
      nl = $urandom_range(0, MTX + 2);
      for (int i = 0; i < nl; i++) begin
        do_load(DW'($urandom_range(0, 255)));
        if ($urandom_range(0, 3) == 0) cyc();
      end
      txl = $urandom_range(0, 20);
      rxl = $urandom_range(0, 10);
      wl  = ($urandom_range(0, 3) == 0);
      m_to_exp = 0;
      do_start(txl, rxl, wl, DW'($urandom_range(0, 255)));
      nw = m_rxlen + $urandom_range(0, 2);
      respond(nw, 0, 0);
      wait_done();
      nd = $urandom_range(0, m_rx.size());
      repeat (nd) drain();
    end

    repeat (3) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, expected completion before t=500000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
